// File: rtl/hex_inverter_emulator.sv
// Six-channel inverter IC emulator with per-channel delay and fault modes.
// Optional glitch injection port/logic enabled by GLITCH_INJECT_EN.
module hex_inverter_emulator #(
  parameter int NUM_CH        = 6,
  parameter int DELAY_W       = 8,
  parameter int DEFAULT_DELAY = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CH-1:0]  a,
`ifdef GLITCH_INJECT_EN
  input  logic [NUM_CH-1:0]  glitch_req,
`endif
  output logic [NUM_CH-1:0]  op,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [2:0]         cfg_ch,
  input  logic [1:0]         cfg_mode,
  input  logic [DELAY_W-1:0] cfg_delay,
  output logic               cfg_err,
  output logic [NUM_CH-1:0]  fault_active
);

  typedef enum logic {
    IDLE,
    PENDING
  } ch_state_e;

  localparam logic [1:0] M_NORM = 2'b00;
  localparam logic [1:0] M_SA0  = 2'b01;
  localparam logic [1:0] M_SA1  = 2'b10;
  localparam logic [1:0] M_BUF  = 2'b11;

  logic [NUM_CH-1:0]  s1;
  logic [NUM_CH-1:0]  s2;
  logic [NUM_CH-1:0]  last;
  logic [NUM_CH-1:0]  chg;

  logic [1:0]         mode_q  [NUM_CH];
  logic [1:0]         mode_n  [NUM_CH];
  logic [DELAY_W-1:0] delay_q [NUM_CH];
  logic [DELAY_W-1:0] delay_n [NUM_CH];
  logic [DELAY_W-1:0] cnt_q   [NUM_CH];
  logic [DELAY_W-1:0] cnt_n   [NUM_CH];
  ch_state_e          state_q [NUM_CH];
  ch_state_e          state_n [NUM_CH];

  logic [NUM_CH-1:0]  op_fsm;
  logic [NUM_CH-1:0]  op_n;
  logic [NUM_CH-1:0]  fault_n;

  logic               xfer;
  logic               cfg_hit;

  function automatic logic gate_fn(
    input logic [1:0] m,
    input logic       x
  );
    logic y;
    y = ~x;
    unique case (m)
      M_NORM: y = ~x;
      M_SA0:  y = 1'b0;
      M_SA1:  y = 1'b1;
      M_BUF:  y = x;
    endcase
    return y;
  endfunction

  assign chg     = s2 ^ last;
  assign xfer    = cfg_valid & cfg_ready;
  assign cfg_hit = xfer && (int'(cfg_ch) < NUM_CH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      last <= '0;
    end else begin
      s1   <= a;
      s2   <= s1;
      last <= s2;
    end
  end

  // A config write overrides change detection; last still tracks s2,
  // so the forced re-evaluation sees the same input either way.
  always_comb begin
    mode_n  = mode_q;
    delay_n = delay_q;
    cnt_n   = cnt_q;
    state_n = state_q;
    op_n    = op_fsm;
    fault_n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_hit && int'(cfg_ch) == i) begin
        mode_n[i]  = cfg_mode;
        delay_n[i] = cfg_delay;
        cnt_n[i]   = cfg_delay;
        state_n[i] = PENDING;
      end else begin
        unique case (state_q[i])
          IDLE: begin
            if (chg[i]) begin
              cnt_n[i]   = delay_q[i];
              state_n[i] = PENDING;
            end
          end
          PENDING: begin
            if (chg[i]) begin
              cnt_n[i] = delay_q[i];
            end else if (cnt_q[i] == '0) begin
              op_n[i]    = gate_fn(mode_q[i], last[i]);
              state_n[i] = IDLE;
            end else begin
              cnt_n[i] = cnt_q[i] - DELAY_W'(1);
            end
          end
        endcase
      end
      fault_n[i] = (mode_n[i] != M_NORM);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]  <= M_NORM;
        delay_q[i] <= DELAY_W'(DEFAULT_DELAY);
        cnt_q[i]   <= '0;
        state_q[i] <= IDLE;
      end
      op_fsm       <= '1;
      fault_active <= '0;
      cfg_ready    <= 1'b1;
      cfg_err      <= 1'b0;
    end else begin
      mode_q       <= mode_n;
      delay_q      <= delay_n;
      cnt_q        <= cnt_n;
      state_q      <= state_n;
      op_fsm       <= op_n;
      fault_active <= fault_n;
      cfg_ready    <= ~xfer;
      cfg_err      <= xfer & ~cfg_hit;
    end
  end

`ifdef GLITCH_INJECT_EN
  logic [NUM_CH-1:0] g_q;
  logic [NUM_CH-1:0] op_q;

  // The glitch only touches the output copy; the FSM keeps op_fsm intact,
  // so the following edge restores (or updates) from the FSM value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q  <= '0;
      op_q <= '1;
    end else begin
      g_q  <= glitch_req;
      op_q <= op_n ^ (glitch_req & ~g_q);
    end
  end

  assign op = op_q;
`else
  assign op = op_fsm;
`endif

endmodule

// File: tb/tb_hex_inverter_emulator.sv
// Directed self-checking bench for hex_inverter_emulator.
// Glitch scenario is compiled only with GLITCH_INJECT_EN.
module tb_hex_inverter_emulator;

  logic       clk;
  logic       rst_n;
  logic [5:0] a;
  logic [5:0] op;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_delay;
  logic       cfg_err;
  logic [5:0] fault_active;
  logic [5:0] glitch_req;

  int n_cmp;
  int n_bad;

  hex_inverter_emulator #(
    .NUM_CH(6),
    .DELAY_W(8),
    .DEFAULT_DELAY(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a(a),
`ifdef GLITCH_INJECT_EN
    .glitch_req(glitch_req),
`endif
    .op(op),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode),
    .cfg_delay(cfg_delay),
    .cfg_err(cfg_err),
    .fault_active(fault_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [2:0] ch,
                           input logic [1:0] m,
                           input logic [7:0] d);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_mode  = m;
    cfg_delay = d;
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    a          = '0;
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_mode   = '0;
    cfg_delay  = '0;
    glitch_req = '0;
    tick(2);
    n_cmp++;
    if (op !== 6'h3f) begin
      n_bad++; $display("FAIL reset_op got=%h exp=3f", op);
    end
    n_cmp++;
    if (cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_cfg got ready=%b err=%b exp ready=1 err=0",
               cfg_ready, cfg_err);
    end
    rst_n = 1'b1;
    tick(6);
    n_cmp++;
    if (op !== 6'h3f) begin
      n_bad++; $display("FAIL idle_op got=%h exp=3f", op);
    end
    n_cmp++;
    if (fault_active !== 6'h00 || cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_cfg got fa=%h ready=%b exp fa=00 ready=1",
               fault_active, cfg_ready);
    end
  endtask

  task automatic test_latency;
    a = 6'h3f;
    for (int m = 0; m < 7; m++) begin
      tick(1);
      n_cmp++;
      if (op !== 6'h3f) begin
        n_bad++; $display("FAIL lat_early edge=k+%0d got=%h exp=3f", m, op);
      end
    end
    tick(1);
    n_cmp++;
    if (op !== 6'h00) begin
      n_bad++; $display("FAIL lat_k7 got=%h exp=00", op);
    end
    a = 6'h00;
    tick(8);
    n_cmp++;
    if (op !== 6'h3f) begin
      n_bad++; $display("FAIL lat_back got=%h exp=3f", op);
    end
  endtask

  task automatic test_stuck0;
    cfg_valid = 1'b1;
    cfg_ch    = 3'd2;
    cfg_mode  = 2'b01;
    cfg_delay = 8'd0;
    tick(1);
    cfg_valid = 1'b0;
    n_cmp++;
    if (cfg_ready !== 1'b0 || fault_active !== 6'b000100) begin
      n_bad++;
      $display("FAIL sa0_apply got ready=%b fa=%b exp ready=0 fa=000100",
               cfg_ready, fault_active);
    end
    tick(1);
    n_cmp++;
    if (cfg_ready !== 1'b1 || op !== 6'b111011) begin
      n_bad++;
      $display("FAIL sa0_after got ready=%b op=%b exp ready=1 op=111011",
               cfg_ready, op);
    end
    a = 6'h3f;
    tick(8);
    n_cmp++;
    if (op !== 6'b000000) begin
      n_bad++; $display("FAIL sa0_high got=%b exp=000000", op);
    end
    a = 6'h00;
    tick(8);
    n_cmp++;
    if (op !== 6'b111011 || fault_active !== 6'b000100) begin
      n_bad++;
      $display("FAIL sa0_low got op=%b fa=%b exp op=111011 fa=000100",
               op, fault_active);
    end
    cfg_write(3'd2, 2'b00, 8'd4);
    tick(6);
    n_cmp++;
    if (op !== 6'h3f || fault_active !== 6'h00) begin
      n_bad++;
      $display("FAIL sa0_restore got op=%h fa=%h exp op=3f fa=00",
               op, fault_active);
    end
  endtask

  task automatic test_modes;
    cfg_write(3'd1, 2'b11, 8'd0);
    cfg_write(3'd3, 2'b10, 8'd0);
    tick(2);
    n_cmp++;
    if (op !== 6'b111101 || fault_active !== 6'b001010) begin
      n_bad++;
      $display("FAIL modes_low got op=%b fa=%b exp op=111101 fa=001010",
               op, fault_active);
    end
    a = 6'h3f;
    tick(8);
    n_cmp++;
    if (op !== 6'b001010) begin
      n_bad++; $display("FAIL modes_high got=%b exp=001010", op);
    end
    a = 6'h00;
    tick(8);
    cfg_write(3'd1, 2'b00, 8'd4);
    cfg_write(3'd3, 2'b00, 8'd4);
    tick(6);
    n_cmp++;
    if (op !== 6'h3f || fault_active !== 6'h00) begin
      n_bad++;
      $display("FAIL modes_restore got op=%h fa=%h exp op=3f fa=00",
               op, fault_active);
    end
  endtask

  task automatic test_inertial;
    logic seen_zero;
    seen_zero = 1'b0;
    cfg_write(3'd0, 2'b00, 8'd10);
    tick(12);
    a = 6'h01;
    for (int m = 0; m < 3; m++) begin
      tick(1);
      if (op[0] !== 1'b1) seen_zero = 1'b1;
    end
    a = 6'h00;
    for (int m = 0; m < 25; m++) begin
      tick(1);
      if (op[0] !== 1'b1) seen_zero = 1'b1;
    end
    n_cmp++;
    if (seen_zero !== 1'b0) begin
      n_bad++; $display("FAIL inertial_glitch got=1 exp=0 (op0 dipped)");
    end
    n_cmp++;
    if (op !== 6'h3f) begin
      n_bad++; $display("FAIL inertial_end got=%h exp=3f", op);
    end
    cfg_write(3'd0, 2'b00, 8'd4);
    tick(6);
  endtask

  task automatic test_delay_bounds;
    cfg_write(3'd3, 2'b00, 8'd0);
    tick(2);
    a = 6'b001000;
    tick(3);
    n_cmp++;
    if (op[3] !== 1'b1) begin
      n_bad++; $display("FAIL d0_early got=%b exp=1", op[3]);
    end
    tick(1);
    n_cmp++;
    if (op[3] !== 1'b0) begin
      n_bad++; $display("FAIL d0_k3 got=%b exp=0", op[3]);
    end
    a = 6'h00;
    tick(4);
    cfg_write(3'd1, 2'b00, 8'd255);
    tick(260);
    a = 6'b000010;
    tick(258);
    n_cmp++;
    if (op[1] !== 1'b1) begin
      n_bad++; $display("FAIL dmax_early got=%b exp=1", op[1]);
    end
    tick(1);
    n_cmp++;
    if (op[1] !== 1'b0) begin
      n_bad++; $display("FAIL dmax_k258 got=%b exp=0", op[1]);
    end
    a = 6'h00;
    tick(3);
    cfg_write(3'd1, 2'b00, 8'd4);
    cfg_write(3'd3, 2'b00, 8'd4);
    tick(8);
    n_cmp++;
    if (op !== 6'h3f) begin
      n_bad++; $display("FAIL dbound_restore got=%h exp=3f", op);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_err;
    logic [3:0] exp_rdy;
    exp_err = 4'b0101;
    exp_rdy = 4'b1010;
    cfg_valid = 1'b1;
    cfg_ch    = 3'd7;
    cfg_mode  = 2'b10;
    cfg_delay = 8'd0;
    for (int m = 0; m < 4; m++) begin
      tick(1);
      if (m == 2) cfg_valid = 1'b0;
      n_cmp++;
      if (cfg_err !== exp_err[m] || cfg_ready !== exp_rdy[m]) begin
        n_bad++;
        $display("FAIL bad_ch cyc=%0d got err=%b rdy=%b exp err=%b rdy=%b",
                 m, cfg_err, cfg_ready, exp_err[m], exp_rdy[m]);
      end
    end
    tick(4);
    n_cmp++;
    if (op !== 6'h3f || fault_active !== 6'h00) begin
      n_bad++;
      $display("FAIL bad_ch_state got op=%h fa=%h exp op=3f fa=00",
               op, fault_active);
    end
    a = 6'h3f;
    tick(7);
    n_cmp++;
    if (op !== 6'h3f) begin
      n_bad++; $display("FAIL bad_ch_delay got=%h exp=3f", op);
    end
    tick(1);
    n_cmp++;
    if (op !== 6'h00) begin
      n_bad++; $display("FAIL bad_ch_func got=%h exp=00", op);
    end
    a = 6'h00;
    tick(8);
  endtask

  task automatic test_reset_mid;
    cfg_write(3'd4, 2'b10, 8'd4);
    n_cmp++;
    if (fault_active !== 6'b010000) begin
      n_bad++; $display("FAIL mid_fa got=%b exp=010000", fault_active);
    end
    a = 6'h3f;
    tick(3);
    rst_n = 1'b0;
    a = 6'h00;
    tick(1);
    n_cmp++;
    if (op !== 6'h3f || fault_active !== 6'h00 || cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_rst got op=%h fa=%h rdy=%b exp op=3f fa=00 rdy=1",
               op, fault_active, cfg_ready);
    end
    rst_n = 1'b1;
    tick(10);
    n_cmp++;
    if (op !== 6'h3f) begin
      n_bad++; $display("FAIL mid_settle got=%h exp=3f", op);
    end
    a = 6'h3f;
    tick(8);
    n_cmp++;
    if (op !== 6'h00) begin
      n_bad++; $display("FAIL mid_mode got=%h exp=00", op);
    end
    a = 6'h00;
    tick(8);
  endtask

`ifdef GLITCH_INJECT_EN
  task automatic test_glitch;
    glitch_req = 6'b100000;
    tick(1);
    n_cmp++;
    if (op !== 6'b011111) begin
      n_bad++; $display("FAIL glitch_on got=%b exp=011111", op);
    end
    tick(1);
    glitch_req = 6'b000000;
    n_cmp++;
    if (op !== 6'h3f) begin
      n_bad++; $display("FAIL glitch_off got=%b exp=111111", op);
    end
    a = 6'b100000;
    tick(7);
    n_cmp++;
    if (op !== 6'h3f) begin
      n_bad++; $display("FAIL glitch_fsm_early got=%b exp=111111", op);
    end
    tick(1);
    n_cmp++;
    if (op !== 6'b011111) begin
      n_bad++; $display("FAIL glitch_fsm got=%b exp=011111", op);
    end
    a = 6'h00;
    tick(8);
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset;
    test_latency;
    test_stuck0;
    test_modes;
    test_inertial;
    test_delay_bounds;
    test_back_to_back;
    test_reset_mid;
`ifdef GLITCH_INJECT_EN
    test_glitch;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
